// File: rtl/ex_mem_skid_if.sv
// Beat channel between pipeline stages: valid/ready handshake plus the EX->MEM payload.
// The master drives valid and payload; the slave answers with ready.
interface ex_mem_skid_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ADDR_W  = 32,
  parameter int OP_W    = 6
);
  logic               valid;
  logic               ready;
  logic [DATA_W-1:0]  rd_data;
  logic [RADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0]  addr;
  logic [OP_W-1:0]    op;

  modport master (
    output valid,
    output rd_data,
    output rd_addr,
    output addr,
    output op,
    input  ready
  );

  modport slave (
    input  valid,
    input  rd_data,
    input  rd_addr,
    input  addr,
    input  op,
    output ready
  );
endinterface

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register built as a 2-entry skid buffer. ex.ready depends only on
// held state, so there is no combinational path from mem.ready back to EX.
module ex_mem_skid #(
  parameter int              DATA_W  = 32,
  parameter int              RADDR_W = 5,
  parameter int              ADDR_W  = 32,
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] NOP_OP  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  ex_mem_skid_if.slave         ex,
  ex_mem_skid_if.master        mem,
  output logic                 mem_new,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  rd_data;
    logic [RADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0]  addr;
    logic [OP_W-1:0]    op;
  } beat_t;

  state_t state;
  state_t state_next;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;

  logic acc;
  logic drn;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_beat.rd_data = ex.rd_data;
  assign in_beat.rd_addr = ex.rd_addr;
  assign in_beat.addr    = ex.addr;
  assign in_beat.op      = ex.op;

  assign ex.ready  = !rst && rdy && (state != FULL);
  assign mem.valid = (state != EMPTY);

  assign acc = rdy && ex.valid && ex.ready;
  assign drn = rdy && mem.valid && mem.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flush wins over any concurrent accept/drain; rdy low freezes everything.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (rdy) begin
      if (flush) begin
        state_next = EMPTY;
      end else begin
        unique case (state)
          EMPTY: begin
            if (acc) begin
              state_next   = ONE;
              load_main_in = 1'b1;
            end
          end
          ONE: begin
            if (acc && drn) begin
              state_next   = ONE;
              load_main_in = 1'b1;
            end else if (acc) begin
              state_next = FULL;
              load_skid  = 1'b1;
            end else if (drn) begin
              state_next = EMPTY;
            end
          end
          FULL: begin
            if (drn) begin
              state_next     = ONE;
              load_main_skid = 1'b1;
            end
          end
          default: begin
            state_next = EMPTY;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_beat;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_new <= 1'b0;
    end else begin
      mem_new <= load_main_in || load_main_skid;
    end
  end

  // Stale payload may sit in main while empty, so only op needs masking.
  assign mem.rd_data = main_q.rd_data;
  assign mem.rd_addr = main_q.rd_addr;
  assign mem.addr    = main_q.addr;
  assign mem.op      = (state == EMPTY) ? NOP_OP : main_q.op;

  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: a queue of expected beats is filled on accept and
// drained against the head presented on the MEM side.
module tb_ex_mem_skid;

  localparam logic [5:0] NOP = 6'h00;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] addr;
  } beat_t;

  logic clk;
  logic rst;
  logic rdy;
  logic flush;
  logic mem_new;
  logic [1:0] occupancy;

  int checks;
  int errors;
  bit exp_new;
  beat_t sb[$];

  ex_mem_skid_if #(.DATA_W(32), .RADDR_W(5), .ADDR_W(32), .OP_W(6)) ex_if ();
  ex_mem_skid_if #(.DATA_W(32), .RADDR_W(5), .ADDR_W(32), .OP_W(6)) mem_if ();

  ex_mem_skid #(
    .DATA_W(32), .RADDR_W(5), .ADDR_W(32), .OP_W(6), .NOP_OP(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .flush(flush),
    .ex(ex_if),
    .mem(mem_if),
    .mem_new(mem_new),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic beat_t make_beat(input logic [5:0] op, input logic [31:0] data);
    beat_t b;
    b.op   = op;
    b.data = data;
    b.rd   = data[4:0] ^ op[4:0];
    b.addr = data ^ 32'h1000_0000;
    return b;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkVal("occupancy", 64'(occupancy), 64'(sb.size()));
    checkVal("mem_valid", 64'(mem_if.valid), 64'(sb.size() != 0));
    checkVal("mem_new", 64'(mem_new), 64'(exp_new));
    if (sb.size() != 0) begin
      checkVal("mem_op", 64'(mem_if.op), 64'(sb[0].op));
      checkVal("mem_rd_data", 64'(mem_if.rd_data), 64'(sb[0].data));
      checkVal("mem_rd_addr", 64'(mem_if.rd_addr), 64'(sb[0].rd));
      checkVal("mem_addr", 64'(mem_if.addr), 64'(sb[0].addr));
    end else begin
      checkVal("mem_op_nop", 64'(mem_if.op), 64'(NOP));
    end
  endtask

  // One clock of stimulus, entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input bit v, input logic [5:0] op, input logic [31:0] data,
                               input bit mready, input bit fl, input bit en);
    beat_t b;
    bit acc;
    bit drn;
    int old_occ;
    b = make_beat(op, data);
    ex_if.valid   = v;
    ex_if.op      = b.op;
    ex_if.rd_data = b.data;
    ex_if.rd_addr = b.rd;
    ex_if.addr    = b.addr;
    mem_if.ready  = mready;
    flush         = fl;
    rdy           = en;
    #1;
    checkVal("ex_ready", 64'(ex_if.ready), 64'(en && sb.size() < 2));
    old_occ = sb.size();
    acc = en && v && (old_occ < 2);
    drn = en && (old_occ > 0) && mready;
    @(posedge clk);
    if (!en) begin
      exp_new = 1'b0;
    end else if (fl) begin
      sb.delete();
      exp_new = 1'b0;
    end else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back(b);
      exp_new = (drn && sb.size() > 0) || (old_occ == 0 && acc);
    end
    #1;
    checkOutput();
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_valid"}, 64'(mem_if.valid), 64'd0);
    checkVal({tag, "_op"}, 64'(mem_if.op), 64'(NOP));
    checkVal({tag, "_new"}, 64'(mem_new), 64'd0);
    checkVal({tag, "_occ"}, 64'(occupancy), 64'd0);
    checkVal({tag, "_ex_ready"}, 64'(ex_if.ready), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_new = 1'b0;
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    ex_if.valid = 1'b0;
    ex_if.op = '0;
    ex_if.rd_data = '0;
    ex_if.rd_addr = '0;
    ex_if.addr = '0;
    mem_if.ready = 1'b0;
    #12;
    checkReset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single beat from empty
    applyStimulus(1, 6'h03, 32'hDEADBEEF, 1, 0, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);

    // back-pressure: fill to FULL, then drain in order
    applyStimulus(1, 6'h01, 32'hA0A0_0001, 0, 0, 1);
    applyStimulus(1, 6'h02, 32'hB0B0_0002, 0, 0, 1);
    applyStimulus(1, 6'h05, 32'hC0C0_0005, 0, 0, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);

    // streaming 8 beats back to back
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 6'(i + 8), 32'(i), 1, 0, 1);
    end
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);

    // fill then flush with a concurrent drain and offer
    applyStimulus(1, 6'h11, 32'h1111_1111, 0, 0, 1);
    applyStimulus(1, 6'h12, 32'h2222_2222, 0, 0, 1);
    applyStimulus(1, 6'h13, 32'h3333_3333, 1, 1, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);

    // freeze with rdy low while holding one beat, then resume
    applyStimulus(1, 6'h21, 32'h0000_2121, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 6'h22, 32'h0000_2222, 1, 0, 0);
    end
    applyStimulus(1, 6'h22, 32'h0000_2222, 1, 0, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);

    // asynchronous reset mid-cycle while FULL
    applyStimulus(1, 6'h31, 32'h0000_3131, 0, 0, 1);
    applyStimulus(1, 6'h32, 32'h0000_3232, 0, 0, 1);
    ex_if.valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkReset("async_rst");
    sb.delete();
    exp_new = 1'b0;
    @(posedge clk);
    #1;
    checkReset("rst_held");
    rst = 1'b0;
    applyStimulus(1, 6'h3F, 32'hFEED_F00D, 1, 0, 1);
    applyStimulus(0, 6'h00, 32'h0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
